// File: rtl/bp_pma_arbiter.sv
// Two-requester arbiter sharing one PMA uncached lookup, with a single-entry response register.
// Build option BP_PMA_ARB_RR_EN selects round-robin ties; default is fixed backend priority.
module bp_pma_arbiter #(
    parameter int unsigned ptag_width_p        = 28,
    parameter int unsigned page_offset_width_p = 12,
    parameter int unsigned io_noc_did_width_p  = 3,
    parameter logic [63:0] dram_base_addr_gp   = 64'h0000_0000_8000_0000
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [1:0]                req_v_i,
    input  logic [2*ptag_width_p-1:0] req_ptag_i,
    output logic [1:0]                req_yumi_o,
    output logic                      resp_v_o,
    output logic                      resp_id_o,
    output logic                      resp_uncached_o,
    output logic [ptag_width_p-1:0]   resp_ptag_o,
    input  logic                      resp_yumi_i
);

    localparam logic [63:0] dram_base_ptag_lp = dram_base_addr_gp >> page_offset_width_p;

    logic                    resp_v_q, resp_v_d;
    logic                    resp_id_q, resp_id_d;
    logic                    resp_uncached_q, resp_uncached_d;
    logic [ptag_width_p-1:0] resp_ptag_q, resp_ptag_d;

    logic                    can_accept;
    logic [1:0]              grant;
    logic                    win_id;
    logic [ptag_width_p-1:0] win_ptag;
    logic [63:0]             win_ptag_ext;
    logic                    win_uncached;

`ifdef BP_PMA_ARB_RR_EN
    logic last_grant_q, last_grant_d;
`endif

    assign can_accept = ~resp_v_q | resp_yumi_i;

    // Grant is suppressed during reset so no request is consumed in a cycle whose load is void.
    always_comb begin
        grant = 2'b00;
        if (!reset_i && can_accept) begin
            unique case (req_v_i)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
`ifdef BP_PMA_ARB_RR_EN
                2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
`else
                2'b11:   grant = 2'b10;
`endif
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_yumi_o   = grant;
    assign win_id       = grant[1];
    assign win_ptag     = win_id ? req_ptag_i[ptag_width_p +: ptag_width_p]
                                 : req_ptag_i[0 +: ptag_width_p];
    assign win_ptag_ext = 64'(win_ptag);
    assign win_uncached = (win_ptag_ext < dram_base_ptag_lp)
                        | (win_ptag[ptag_width_p-1 -: io_noc_did_width_p] != '0);

    always_comb begin
        resp_v_d        = resp_v_q;
        resp_id_d       = resp_id_q;
        resp_uncached_d = resp_uncached_q;
        resp_ptag_d     = resp_ptag_q;
        if (grant != 2'b00) begin
            resp_v_d        = 1'b1;
            resp_id_d       = win_id;
            resp_uncached_d = win_uncached;
            resp_ptag_d     = win_ptag;
        end else if (resp_yumi_i) begin
            resp_v_d = 1'b0;
        end
    end

`ifdef BP_PMA_ARB_RR_EN
    always_comb begin
        last_grant_d = last_grant_q;
        if (grant != 2'b00) begin
            last_grant_d = win_id;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            resp_v_q        <= 1'b0;
            resp_id_q       <= 1'b0;
            resp_uncached_q <= 1'b0;
            resp_ptag_q     <= '0;
        end else begin
            resp_v_q        <= resp_v_d;
            resp_id_q       <= resp_id_d;
            resp_uncached_q <= resp_uncached_d;
            resp_ptag_q     <= resp_ptag_d;
        end
    end

    assign resp_v_o        = resp_v_q;
    assign resp_id_o       = resp_id_q;
    assign resp_uncached_o = resp_uncached_q;
    assign resp_ptag_o     = resp_ptag_q;

endmodule

// File: tb/tb_bp_pma_arbiter.sv
// Scoreboard bench for bp_pma_arbiter: stimulus queues hand-computed results, a monitor
// pops one entry for each response load it observes.
module tb_bp_pma_arbiter;

    localparam int unsigned PW = 28;

    logic          clk = 1'b0;
    logic          reset_i;
    logic [1:0]    req_v_i;
    logic [2*PW-1:0] req_ptag_i;
    logic [1:0]    req_yumi_o;
    logic          resp_v_o;
    logic          resp_id_o;
    logic          resp_uncached_o;
    logic [PW-1:0] resp_ptag_o;
    logic          resp_yumi_i;

    typedef struct packed {
        logic          id;
        logic          unc;
        logic [PW-1:0] ptag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic pending  = 1'b0;

    bp_pma_arbiter #(
        .ptag_width_p       (28),
        .page_offset_width_p(12),
        .io_noc_did_width_p (3),
        .dram_base_addr_gp  (64'h0000_0000_8000_0000)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .req_v_i        (req_v_i),
        .req_ptag_i     (req_ptag_i),
        .req_yumi_o     (req_yumi_o),
        .resp_v_o       (resp_v_o),
        .resp_id_o      (resp_id_o),
        .resp_uncached_o(resp_uncached_o),
        .resp_ptag_o    (resp_ptag_o),
        .resp_yumi_i    (resp_yumi_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // One cycle of stimulus; the consumer only accepts while a response is actually held.
    task automatic step(input logic rst, input logic [1:0] v, input logic [PW-1:0] p0,
                        input logic [PW-1:0] p1, input logic consume);
        @(posedge clk);
        #1;
        reset_i     = rst;
        req_v_i     = v;
        req_ptag_i  = {p1, p0};
        resp_yumi_i = consume & resp_v_o;
        @(negedge clk);
    endtask

    task automatic push(input logic id, input logic [PW-1:0] ptag, input logic unc);
        exp_t e;
        e.id   = id;
        e.unc  = unc;
        e.ptag = ptag;
        exp_q.push_back(e);
    endtask

    // Monitor: a grant seen at one negedge must appear as a loaded response at the next.
    always @(negedge clk) begin
        exp_t e;
        if (pending) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_resp: got id=%0d ptag=0x%0h expected no response",
                         resp_id_o, resp_ptag_o);
            end else begin
                e = exp_q.pop_front();
                chk("resp_v", 64'(resp_v_o), 64'd1);
                chk("resp_id", 64'(resp_id_o), 64'(e.id));
                chk("resp_ptag", 64'(resp_ptag_o), 64'(e.ptag));
                chk("resp_uncached", 64'(resp_uncached_o), 64'(e.unc));
            end
        end
        if (req_yumi_o == 2'b11) begin
            n_checks++;
            $display("FAIL yumi_onehot: got %b expected at most one bit", req_yumi_o);
        end
        pending = (req_yumi_o != 2'b00) && !reset_i;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] tie_win [4];
        logic [1:0] post_rst_win;
        reset_i     = 1'b1;
        req_v_i     = 2'b00;
        req_ptag_i  = '0;
        resp_yumi_i = 1'b0;
`ifdef BP_PMA_ARB_RR_EN
        tie_win      = '{2'b10, 2'b01, 2'b10, 2'b01};
        post_rst_win = 2'b01;
`else
        tie_win      = '{2'b10, 2'b10, 2'b10, 2'b10};
        post_rst_win = 2'b10;
`endif

        // Reset state, with both requesters asserting to prove yumi is held low.
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 2'b11, 28'h0000100, 28'h0080000, 1'b0);
            chk("rst_yumi", 64'(req_yumi_o), 64'd0);
            chk("rst_resp_v", 64'(resp_v_o), 64'd0);
            chk("rst_resp_id", 64'(resp_id_o), 64'd0);
            chk("rst_resp_unc", 64'(resp_uncached_o), 64'd0);
            chk("rst_resp_ptag", 64'(resp_ptag_o), 64'd0);
        end

        // Single requests and attribute boundaries.
        step(1'b0, 2'b01, 28'h0000100, 28'h0, 1'b1);
        chk("single_yumi", 64'(req_yumi_o), 64'd1);
        push(1'b0, 28'h0000100, 1'b1);
        step(1'b0, 2'b01, 28'h0080000, 28'h0, 1'b1);
        chk("cached_yumi", 64'(req_yumi_o), 64'd1);
        push(1'b0, 28'h0080000, 1'b0);
        step(1'b0, 2'b10, 28'h0, 28'h2000000, 1'b1);
        chk("io_yumi", 64'(req_yumi_o), 64'd2);
        push(1'b1, 28'h2000000, 1'b1);
        step(1'b0, 2'b01, 28'h007FFFF, 28'h0, 1'b1);
        chk("below_dram_yumi", 64'(req_yumi_o), 64'd1);
        push(1'b0, 28'h007FFFF, 1'b1);

        // Back-to-back from requester 1 with the consumer always ready.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 2'b10, 28'h0, 28'h0080000 + 28'(i), 1'b1);
            chk("b2b_yumi", 64'(req_yumi_o), 64'd2);
            push(1'b1, 28'h0080000 + 28'(i), 1'b0);
        end
        step(1'b0, 2'b00, 28'h0, 28'h0, 1'b1);
        chk("idle_yumi", 64'(req_yumi_o), 64'd0);

        // Backpressure: fill, stall with both valid, then release.
        step(1'b0, 2'b01, 28'h0012345, 28'h0, 1'b0);
        chk("fill_yumi", 64'(req_yumi_o), 64'd1);
        push(1'b0, 28'h0012345, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'b11, 28'hE000000, 28'h0F00000, 1'b0);
            chk("stall_yumi", 64'(req_yumi_o), 64'd0);
            chk("stall_resp_ptag", 64'(resp_ptag_o), 64'h0012345);
        end

        // Continuous tie with the consumer ready; release happens on the first iteration.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 2'b11, 28'hE000000, 28'h0F00000, 1'b1);
            chk("tie_yumi", 64'(req_yumi_o), 64'(tie_win[i]));
            if (tie_win[i] == 2'b10) push(1'b1, 28'h0F00000, 1'b0);
            else                     push(1'b0, 28'hE000000, 1'b1);
        end

        // Full again, then reset mid-stream.
        step(1'b0, 2'b11, 28'hE000000, 28'h0F00000, 1'b0);
        chk("full_yumi", 64'(req_yumi_o), 64'd0);
        step(1'b1, 2'b11, 28'hE000000, 28'h0F00000, 1'b0);
        chk("midrst_yumi", 64'(req_yumi_o), 64'd0);
        step(1'b0, 2'b11, 28'hE000000, 28'h0F00000, 1'b0);
        chk("postrst_resp_v", 64'(resp_v_o), 64'd0);
        chk("postrst_tie_yumi", 64'(req_yumi_o), 64'(post_rst_win));
        if (post_rst_win == 2'b10) push(1'b1, 28'h0F00000, 1'b0);
        else                       push(1'b0, 28'hE000000, 1'b1);

        step(1'b0, 2'b00, 28'h0, 28'h0, 1'b1);
        step(1'b0, 2'b00, 28'h0, 28'h0, 1'b0);
        chk("drained_resp_v", 64'(resp_v_o), 64'd0);
        step(1'b0, 2'b00, 28'h0, 28'h0, 1'b0);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
